// File: rtl/uart_pkg.sv
// Shared UART definitions used by both link ends: receiver state encoding,
// frame geometry and the parity convention agreed with the transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS  = 32;
    localparam int UART_FRAME_BITS = UART_DATA_BITS + 3;

    // Even parity: data bits XOR parity bit must come out as this value.
    localparam logic UART_PARITY_EVEN = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        PARITY  = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_paritychk.sv
// Serial even-parity accumulator for the UART receiver.
// Only present when UART_RX_PARITY_EN is defined.
`ifdef UART_RX_PARITY_EN
module uart_paritychk
    import uart_pkg::*;
(
    input  logic CLK_Baudin,
    input  logic RstTx,
    input  logic clear,
    input  logic sample_en,
    input  logic serial_bit,
    output logic parity_err
);

    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = 1'b0;
        end else if (sample_en) begin
            acc_d = acc_q ^ serial_bit;
        end
    end

    always_ff @(posedge CLK_Baudin or posedge RstTx) begin
        if (RstTx) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Meaningful only while serial_bit carries the parity sample.
    assign parity_err = (acc_q ^ serial_bit) != UART_PARITY_EVEN;

endmodule
`endif

// File: rtl/uart_rx.sv
// UART receiver sampling one line bit per baud clock: start, data LSB first,
// even parity, stop. Parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int size = UART_DATA_BITS
) (
    input  logic            CLK_Baudin,
    input  logic            RstTx,
    input  logic            RxSerialData,
    output logic [size-1:0] DataOut,
    output logic            DataValid,
    output logic            ParityErr,
    output logic            FrameErr,
    output logic            BusyRx
);

    localparam int CNT_W = $clog2(size) + 1;

    uart_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [size-1:0]  shift_q, shift_d;
    logic [size-1:0]  data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;

`ifdef UART_RX_PARITY_EN
    logic chk_err;
    logic par_flag_q, par_flag_d;
    logic parity_err_q, parity_err_d;

    uart_paritychk u_paritychk (
        .CLK_Baudin (CLK_Baudin),
        .RstTx      (RstTx),
        .clear      ((state_q == IDLE) && !RxSerialData),
        .sample_en  (state_q == DATA),
        .serial_bit (RxSerialData),
        .parity_err (chk_err)
    );
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flag_d   = par_flag_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!RxSerialData) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            DATA: begin
                shift_d = {RxSerialData, shift_q[size-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(size - 1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                par_flag_d = chk_err;
`endif
                state_d = STOP;
            end
            STOP: begin
                if (RxSerialData) begin
                    data_out_d   = shift_q;
                    data_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_flag_q;
`endif
                    state_d      = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = RECOVER;
                end
            end
            // A broken stop bit leaves the line low; wait for it to idle first.
            RECOVER: begin
                if (RxSerialData) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_Baudin or posedge RstTx) begin
        if (RstTx) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_flag_q   <= par_flag_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign DataOut   = data_out_q;
    assign DataValid = data_valid_q;
    assign FrameErr  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign ParityErr = parity_err_q;
`else
    assign ParityErr = 1'b0;
`endif
    // Busy also covers the strobe cycle, which is already back in IDLE.
    assign BusyRx = (state_q != IDLE) || data_valid_q || frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected strobes, a negedge
// monitor pops and compares them whenever the receiver raises a strobe.
module tb_uart_rx;

    logic        CLK_Baudin = 1'b0;
    logic        RstTx;
    logic        RxSerialData;
    logic [31:0] DataOut;
    logic        DataValid;
    logic        ParityErr;
    logic        FrameErr;
    logic        BusyRx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        logic        perr;
        int          cyc;
    } exp_t;

    exp_t valid_q[$];
    int   ferr_q[$];

    uart_rx #(.size(32)) dut (
        .CLK_Baudin   (CLK_Baudin),
        .RstTx        (RstTx),
        .RxSerialData (RxSerialData),
        .DataOut      (DataOut),
        .DataValid    (DataValid),
        .ParityErr    (ParityErr),
        .FrameErr     (FrameErr),
        .BusyRx       (BusyRx)
    );

    always #5 CLK_Baudin = ~CLK_Baudin;

    always @(posedge CLK_Baudin) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge CLK_Baudin);
        RxSerialData = b;
    endtask

    // Strobe is seen at the negedge 35 posedges after the start bit is driven.
    task automatic send_frame(input logic [31:0] data, input logic par, input logic stop);
        exp_t e;
        @(negedge CLK_Baudin);
        RxSerialData = 1'b0;
        e.cyc  = cyc + 35;
        e.data = data;
`ifdef UART_RX_PARITY_EN
        e.perr = par ^ (^data);
`else
        e.perr = 1'b0;
`endif
        for (int i = 0; i < 32; i++) send_bit(data[i]);
        send_bit(par);
        send_bit(stop);
        if (stop) valid_q.push_back(e);
        else      ferr_q.push_back(e.cyc);
    endtask

    always @(negedge CLK_Baudin) begin : monitor
        exp_t e;
        int   fc;
        if (DataValid) begin
            if (valid_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got DataOut=0x%08h expected no strobe", DataOut);
            end else begin
                e = valid_q.pop_front();
                check("data_out", DataOut, e.data);
                check("parity_err", {31'b0, ParityErr}, {31'b0, e.perr});
                check("valid_cycle", cyc, e.cyc);
            end
        end else if (ParityErr) begin
            checks++;
            errors++;
            $display("[TB] FAIL parity_without_valid: got ParityErr=1 expected 0");
        end
        if (FrameErr) begin
            if (ferr_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_frame_err: got FrameErr=1 expected 0");
            end else begin
                fc = ferr_q.pop_front();
                check("frame_err_cycle", cyc, fc);
                check("valid_with_frame_err", {31'b0, DataValid}, 32'h0);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic quiet_seen;
        RstTx        = 1'b1;
        RxSerialData = 1'b1;
        repeat (3) @(negedge CLK_Baudin);
        check("reset_data_out", DataOut, 32'h0);
        check("reset_flags", {28'b0, DataValid, ParityErr, FrameErr, BusyRx}, 32'h0);
        RstTx = 1'b0;
        repeat (2) send_bit(1'b1);

        send_frame(32'hA5A50F0F, 1'b0, 1'b1);
        send_bit(1'b1);
        check("busy_in_strobe_cycle", {31'b0, BusyRx}, 32'h1);
        send_bit(1'b1);
        check("busy_after_frame", {31'b0, BusyRx}, 32'h0);

        send_frame(32'h00000001, 1'b0, 1'b1);
        repeat (2) send_bit(1'b1);

        send_frame(32'h12345678, 1'b1, 1'b0);
        repeat (5) send_bit(1'b0);
        check("busy_in_recover", {31'b0, BusyRx}, 32'h1);
        check("data_out_hold", DataOut, 32'h00000001);
        send_bit(1'b1);
        send_bit(1'b1);
        check("recover_exit_idle", {31'b0, BusyRx}, 32'h0);

        send_bit(1'b0);
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        @(posedge CLK_Baudin);
        #2;
        RstTx        = 1'b1;
        RxSerialData = 1'b1;
        #1;
        check("midreset_data_out", DataOut, 32'h0);
        check("midreset_flags", {28'b0, DataValid, ParityErr, FrameErr, BusyRx}, 32'h0);
        @(negedge CLK_Baudin);
        RstTx = 1'b0;
        send_bit(1'b1);

        send_frame(32'hFFFFFFFF, 1'b0, 1'b1);
        repeat (2) send_bit(1'b1);

        send_frame(32'hDEADBEEF, 1'b0, 1'b1);
        send_frame(32'h00000000, 1'b0, 1'b1);
        repeat (2) send_bit(1'b1);

        quiet_seen = 1'b0;
        repeat (100) begin
            send_bit(1'b1);
            if (BusyRx || DataValid || FrameErr || ParityErr) quiet_seen = 1'b1;
        end
        check("idle_quiet", {31'b0, quiet_seen}, 32'h0);

        for (int i = 0; i < 50 && (valid_q.size() != 0 || ferr_q.size() != 0); i++)
            @(negedge CLK_Baudin);
        check("pending_strobes", valid_q.size() + ferr_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the team's 32-bit UART link, clocked by the baud clock and sampling one line bit per clock. It deserialises frames of start bit (0), `size` data bits LSB first, one even-parity bit and one stop bit (1). It presents the word with a one-cycle valid strobe and flags parity and framing errors. It sits at the far end of the link from the transmitter and shares its baud clock, so no oversampling is used.

## Interface
- `size`, 32, number of data bits per frame
- `CLK_Baudin`  in  1  baud clock; the line is sampled on every posedge
- `RstTx`  in  1  reset, asynchronous, active-high
- `RxSerialData`  in  1  serial line; idles high
- `DataOut`  out  `size`  last received word
- `DataValid`  out  1  one-cycle strobe: a frame with a good stop bit was received
- `ParityErr`  out  1  one-cycle strobe, coincident with `DataValid`: parity mismatch
- `FrameErr`  out  1  one-cycle strobe: stop bit sampled as 0
- `BusyRx`  out  1  high from the cycle after start detection until frame end

## Operation
- Frame length is `size`+3 bits. Parity is even: the parity bit equals the XOR of all data bits.
- **IDLE**
  - `RxSerialData`==0 at a posedge is taken as the start bit.
  - On that edge: → DATA, bit counter cleared, shift register cleared.
- **DATA**
  - Each posedge: shift <= {RxSerialData, shift[size-1:1]}; counter++.
  - After `size` samples: → PARITY.
  - Counter width is $clog2(size)+1.
- **PARITY**
  - One sample. A parity-error flag is registered as RxSerialData ^ (^shift).
  - → STOP.
- **STOP**
  - One sample.
  - If 1: DataOut <= shift, DataValid <= 1, ParityErr <= flag, → IDLE.
  - If 0: FrameErr <= 1, DataOut unchanged, DataValid stays 0, → RECOVER.
- **RECOVER**
  - Wait until RxSerialData==1, then → IDLE.
  - No start detection occurs while the line stays low.
- **Encoding:** any illegal state → IDLE on the next edge.
- **Reset** (asynchronous, any time, including mid-frame):
  - State → IDLE, counter 0, shift 0.
  - DataOut 0, DataValid 0, ParityErr 0, FrameErr 0, BusyRx 0.
  - A partial frame is discarded with no strobe.
- **Start detection:** a single low sample in IDLE is always a start bit. There is no glitch rejection.

## Timing
- Start bit sampled at edge E0. Data bit k (LSB = 0) is sampled at E(k+1), parity at E(size+1), stop at E(size+2).
- Strobes (`DataValid`, `ParityErr`, `FrameErr`) are registered at E(size+2) and are high for exactly the cycle following it.
- Latency: `DataValid` is high `size`+2 cycles after the start-bit edge (34 cycles for `size`=32).
- `BusyRx` is high from the cycle after E0 up to and including the cycle after E(size+2). It also stays high while in RECOVER.
- Back-to-back frames: a start bit sampled at E(size+3), the edge immediately after the stop bit, must be accepted. No idle gap is required.
- `DataOut` holds its value until the next good-stop frame.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined: parity is checked and `ParityErr` is driven as above.
- Undefined:
  - The parity bit is still consumed; frame length and timing are unchanged.
  - `ParityErr` is tied to 0.
  - No parity-check logic is instantiated.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding constants IDLE, DATA, PARITY, STOP, RECOVER (3-bit);
  - `UART_FRAME_BITS` = size+3;
  - the even-parity convention constant, shared with the transmit side.
- One sub-module, `uart_paritychk`: a serial even-parity accumulator.
  - Cleared at start detection; fed each data sample.
  - Compares against the parity sample.
  - Compiled only under `UART_RX_PARITY_EN`.

## Test plan
- Reset, then frame 0xA5A50F0F, parity 0, stop 1 → `DataOut`=0xA5A50F0F, `DataValid` high 1 cycle, 34 cycles after the start edge; `ParityErr`=0, `FrameErr`=0.
- Frame 0x00000001 sent with parity bit 0 → `DataValid`=1 and `ParityErr`=1 in the same cycle. With the macro undefined, `ParityErr`=0.
- After the test above, frame 0x12345678 with stop bit 0, then the line held low 5 cycles before going high → `FrameErr` pulses once, `DataValid` stays 0, `DataOut` keeps 0x00000001. No new frame starts until the line goes high and then low again.
- Assert `RstTx` mid-frame after 10 data bits → all outputs 0 immediately, no strobe. A following frame 0xFFFFFFFF (parity 0) → `DataOut`=0xFFFFFFFF, no errors.
- Two back-to-back frames 0xDEADBEEF then 0x00000000, the second start bit immediately after the first stop bit → two `DataValid` strobes 35 cycles apart with the correct words.
- Line held high 100 cycles → no strobes, `BusyRx`=0 throughout.
